// File: rtl/if_prefetch.sv
// Instruction-fetch stage: issues sequential ROM reads ahead of decode into a
// small {pc, inst} FIFO, flushing everything on a branch redirect.
module if_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_en_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              r_enable_o,
  input  logic              rom_busy_i,
  input  logic              rom_done_i,
  input  logic [INST_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              stall_req_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              r_enable_q, r_enable_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] last_pc_q;
  logic [INST_W-1:0] last_inst_q;
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  logic credit_c;
  logic push_c;
  logic pop_c;
  logic empty_c;

  assign empty_c  = (count_q == '0);
  // An in-flight request reserves a slot so its data always has room.
  assign credit_c = (count_q + CNT_W'(state_q != S_IDLE)) < CNT_W'(DEPTH);
  assign pop_c    = !empty_c && !stall_i && !branch_en_i;

  // Next-state logic for the request FSM and the FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rom_addr_d = rom_addr_q;
    r_enable_d = 1'b0;
    push_c     = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE: begin
        if (credit_c && !rom_busy_i && !branch_en_i) begin
          r_enable_d = 1'b1;
          rom_addr_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_en_i) begin
          state_d = rom_done_i ? S_IDLE : S_DISCARD;
        end else if (rom_done_i) begin
          push_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (rom_done_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (branch_en_i) begin
      fetch_pc_d = branch_addr_i;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Head is read straight from the FIFO; while empty the last shown entry persists.
  assign pc_o         = empty_c ? last_pc_q   : pc_mem_q[rd_ptr_q];
  assign inst_o       = empty_c ? last_inst_q : inst_mem_q[rd_ptr_q];
  assign inst_valid_o = !empty_c;
  assign stall_req_o  = empty_c && rst_n;
  assign rom_addr_o   = rom_addr_q;
  assign r_enable_o   = r_enable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      rom_addr_q  <= '0;
      r_enable_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      last_pc_q   <= '0;
      last_inst_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rom_addr_q  <= rom_addr_d;
      r_enable_q  <= r_enable_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      last_pc_q   <= pc_o;
      last_inst_q <= inst_o;
      if (push_c) begin
        pc_mem_q[wr_ptr_q]   <= rom_addr_q;
        inst_mem_q[wr_ptr_q] <= rom_data_i;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed cycle-by-cycle bench for if_prefetch, plus an 8-bit-address
// instance for the busy/wrap-around case.
module tb_if_prefetch;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] baddr;
    logic        busy;
    logic        done;
    logic [31:0] data;
    logic        e_ren;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_sreq;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br, busy, done;
  logic [31:0] baddr, data;
  logic [31:0] rom_addr, pc, inst;
  logic        ren, valid, sreq;

  logic        rst8_n, stall8, br8, busy8, done8;
  logic [7:0]  baddr8, rom_addr8, pc8;
  logic [15:0] data8, inst8;
  logic        ren8, valid8, sreq8;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h100), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_en_i(br), .branch_addr_i(baddr),
    .rom_addr_o(rom_addr), .r_enable_o(ren), .rom_busy_i(busy), .rom_done_i(done),
    .rom_data_i(data), .pc_o(pc), .inst_o(inst), .inst_valid_o(valid), .stall_req_o(sreq)
  );

  if_prefetch #(.ADDR_W(8), .INST_W(16), .DEPTH(4), .RESET_PC(8'hFC), .PC_STEP(4)) dut8 (
    .clk(clk), .rst_n(rst8_n), .stall_i(stall8), .branch_en_i(br8), .branch_addr_i(baddr8),
    .rom_addr_o(rom_addr8), .r_enable_o(ren8), .rom_busy_i(busy8), .rom_done_i(done8),
    .rom_data_i(data8), .pc_o(pc8), .inst_o(inst8), .inst_valid_o(valid8), .stall_req_o(sreq8)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  function automatic vec_t mk(input logic st, input logic b, input logic [31:0] ba,
                              input logic bz, input logic dn, input logic [31:0] d,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei, input logic es);
    vec_t v;
    v.stall = st; v.br = b; v.baddr = ba; v.busy = bz; v.done = dn; v.data = d;
    v.e_ren = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_inst = ei; v.e_sreq = es;
    return v;
  endfunction

  task automatic check_outs(input int idx, input vec_t v);
    chk("r_enable", idx, 32'(ren), 32'(v.e_ren));
    chk("rom_addr", idx, rom_addr, v.e_addr);
    chk("inst_valid", idx, 32'(valid), 32'(v.e_valid));
    chk("pc", idx, pc, v.e_pc);
    chk("inst", idx, inst, v.e_inst);
    chk("stall_req", idx, 32'(sreq), 32'(v.e_sreq));
  endtask

  // Drive inputs, take one edge, compare the post-edge outputs.
  task automatic step(input int idx, input vec_t v);
    stall = v.stall; br = v.br; baddr = v.baddr; busy = v.busy; done = v.done; data = v.data;
    @(posedge clk);
    #1;
    check_outs(idx, v);
  endtask

  task automatic step8(input int idx, input logic st, input logic bz, input logic dn,
                       input logic [15:0] d, input logic er, input logic [7:0] ea,
                       input logic ev, input logic [7:0] ep, input logic es);
    stall8 = st; busy8 = bz; done8 = dn; data8 = d;
    @(posedge clk);
    #1;
    chk("w_r_enable", idx, 32'(ren8), 32'(er));
    chk("w_rom_addr", idx, 32'(rom_addr8), 32'(ea));
    chk("w_inst_valid", idx, 32'(valid8), 32'(ev));
    chk("w_pc", idx, 32'(pc8), 32'(ep));
    chk("w_stall_req", idx, 32'(sreq8), 32'(es));
  endtask

  vec_t vq[$];
  vec_t zero_v;

  initial begin
    rst_n = 1'b0; stall = 0; br = 0; baddr = 0; busy = 0; done = 0; data = 0;
    rst8_n = 1'b0; stall8 = 0; br8 = 0; baddr8 = 0; busy8 = 0; done8 = 0; data8 = 0;

    //      st br baddr     bz dn data            ren addr       v  pc         inst           sreq
    // reset release, sequential fetch at ROM latency 2, no stall
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          1, 32'h100, 0, 32'h0,   32'h0,          1));
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          0, 32'h100, 0, 32'h0,   32'h0,          1));
    vq.push_back(mk(0, 0, 32'h0,   0, 1, 32'hC0DE0100,   0, 32'h100, 1, 32'h100, 32'hC0DE0100,   0));
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          1, 32'h104, 0, 32'h100, 32'hC0DE0100,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          0, 32'h104, 0, 32'h100, 32'hC0DE0100,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 1, 32'hC0DE0104,   0, 32'h104, 1, 32'h104, 32'hC0DE0104,   0));
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          1, 32'h108, 0, 32'h104, 32'hC0DE0104,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          0, 32'h108, 0, 32'h104, 32'hC0DE0104,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 1, 32'hC0DE0108,   0, 32'h108, 1, 32'h108, 32'hC0DE0108,   0));
    // stall held: fill to DEPTH entries (108,10C,110,114)
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          1, 32'h10C, 1, 32'h108, 32'hC0DE0108,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          0, 32'h10C, 1, 32'h108, 32'hC0DE0108,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 32'hC0DE010C,   0, 32'h10C, 1, 32'h108, 32'hC0DE0108,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          1, 32'h110, 1, 32'h108, 32'hC0DE0108,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          0, 32'h110, 1, 32'h108, 32'hC0DE0108,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 32'hC0DE0110,   0, 32'h110, 1, 32'h108, 32'hC0DE0108,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          1, 32'h114, 1, 32'h108, 32'hC0DE0108,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          0, 32'h114, 1, 32'h108, 32'hC0DE0108,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 32'hC0DE0114,   0, 32'h114, 1, 32'h108, 32'hC0DE0108,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          0, 32'h114, 1, 32'h108, 32'hC0DE0108,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          0, 32'h114, 1, 32'h108, 32'hC0DE0108,   0));
    // one pop frees credit; request follows one edge later
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          0, 32'h114, 1, 32'h10C, 32'hC0DE010C,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          1, 32'h118, 1, 32'h10C, 32'hC0DE010C,   0));
    // redirect while waiting on 0x118: stale data discarded, FIFO empty
    vq.push_back(mk(1, 1, 32'h200, 0, 0, 32'h0,          0, 32'h118, 0, 32'h10C, 32'hC0DE010C,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 1, 32'hC0DE0118,   0, 32'h118, 0, 32'h10C, 32'hC0DE010C,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          1, 32'h200, 0, 32'h10C, 32'hC0DE010C,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          0, 32'h200, 0, 32'h10C, 32'hC0DE010C,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 1, 32'hC0DE0200,   0, 32'h200, 1, 32'h200, 32'hC0DE0200,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          1, 32'h204, 1, 32'h200, 32'hC0DE0200,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          0, 32'h204, 1, 32'h200, 32'hC0DE0200,   0));
    // redirect coincident with done and a would-be pop
    vq.push_back(mk(0, 1, 32'h300, 0, 1, 32'hC0DE0204,   0, 32'h204, 0, 32'h200, 32'hC0DE0200,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          1, 32'h300, 0, 32'h200, 32'hC0DE0200,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          0, 32'h300, 0, 32'h200, 32'hC0DE0200,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 1, 32'hC0DE0300,   0, 32'h300, 1, 32'h300, 32'hC0DE0300,   0));
    // redirect from IDLE, with stray done pulses while IDLE
    vq.push_back(mk(1, 1, 32'h400, 0, 1, 32'h00000BAD,   0, 32'h300, 0, 32'h300, 32'hC0DE0300,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 1, 32'h00000BAD,   1, 32'h400, 0, 32'h300, 32'hC0DE0300,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 32'h0,          0, 32'h400, 0, 32'h300, 32'hC0DE0300,   1));
    vq.push_back(mk(0, 0, 32'h0,   0, 1, 32'hC0DE0400,   0, 32'h400, 1, 32'h400, 32'hC0DE0400,   0));
    // ROM busy blocks the strobe
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,          0, 32'h400, 1, 32'h400, 32'hC0DE0400,   0));
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 32'h0,          0, 32'h400, 1, 32'h400, 32'hC0DE0400,   0));
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,          1, 32'h404, 1, 32'h400, 32'hC0DE0400,   0));

    // reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    zero_v = mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    check_outs(-1, zero_v);
    chk("w_reset_ren", -1, 32'(ren8), 32'h0);
    chk("w_reset_sreq", -1, 32'(sreq8), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("stall_req_after_release", -1, 32'(sreq), 32'h1);

    foreach (vq[i]) step(i, vq[i]);

    // async reset mid-WAIT (request 0x404 outstanding)
    #2 rst_n = 1'b0;
    #1;
    check_outs(100, zero_v);
    #1;
    rst_n = 1'b1;
    step(101, mk(0, 0, 32'h0, 0, 1, 32'h00000BAD, 1, 32'h100, 0, 32'h0, 32'h0, 1));
    step(102, mk(0, 0, 32'h0, 0, 0, 32'h0,        0, 32'h100, 0, 32'h0, 32'h0, 1));
    step(103, mk(0, 0, 32'h0, 0, 1, 32'hC0DE0100, 0, 32'h100, 1, 32'h100, 32'hC0DE0100, 0));

    // 8-bit address instance: busy for 3 edges, then fetch 0xFC and wrap to 0x00
    rst8_n = 1'b1;
    step8(200, 0, 1, 0, 16'h0,    0, 8'h00, 0, 8'h00, 1);
    step8(201, 0, 1, 0, 16'h0,    0, 8'h00, 0, 8'h00, 1);
    step8(202, 0, 1, 0, 16'h0,    0, 8'h00, 0, 8'h00, 1);
    step8(203, 0, 0, 0, 16'h0,    1, 8'hFC, 0, 8'h00, 1);
    step8(204, 0, 0, 0, 16'h0,    0, 8'hFC, 0, 8'h00, 1);
    step8(205, 0, 0, 1, 16'hABFC, 0, 8'hFC, 1, 8'hFC, 0);
    chk("w_inst", 205, 32'(inst8), 32'h0000ABFC);
    step8(206, 0, 0, 0, 16'h0,    1, 8'h00, 0, 8'hFC, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
